// File: rtl/gpio_irq_ctrl_if.sv
// CPU register port for the GPIO interrupt controller.
// Write strobe and data go in; registered read data comes back.
interface gpio_irq_ctrl_if #(parameter int data_width = 4);
  logic [1:0]            addr;
  logic                  we;
  logic [data_width-1:0] wdata;
  logic [data_width-1:0] rdata;

  modport master (output addr, we, wdata, input rdata);
  modport slave  (input addr, we, wdata, output rdata);
endinterface

// File: rtl/gpio_irq_ctrl.sv
// GPIO switch conditioning and interrupt controller: per-bit 2-flop sync,
// debounce and edge detect, then MASK/EDGE/PENDING registers and a level irq.
module gpio_dbnc_lane #(
  parameter int debounce_cycles = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  input  logic edge_sel_i,
  output logic stable_o,
  output logic hit_o
);
  localparam int CW = $clog2(debounce_cycles);
  localparam logic [CW-1:0] CMAX = CW'(debounce_cycles - 1);

  logic          s1_q, s2_q, stable_q, stable_d, accept;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    accept   = (s2_q != stable_q) && (cnt_q == CMAX);
    stable_d = accept ? s2_q : stable_q;
    cnt_d    = cnt_q + 1'b1;
    if ((s2_q == stable_q) || accept) cnt_d = '0;
    // edge_sel 1 = rising, so a hit is a new level equal to the select bit
    hit_o    = accept && (s2_q == edge_sel_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= sw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
endmodule

module gpio_irq_ctrl #(
  parameter int data_width      = 4,
  parameter int debounce_cycles = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] sw_i,
  gpio_irq_ctrl_if.slave        bus,
  output logic [data_width-1:0] sw_state_o,
  output logic                  irq_o
);
  logic [data_width-1:0] stable, hit;
  logic [data_width-1:0] mask_q, mask_d, edge_q, edge_d, pend_q, pend_d, rdata_q, rdata_d;
  logic                  irq_q;

  for (genvar i = 0; i < data_width; i++) begin : g_lane
    gpio_dbnc_lane #(.debounce_cycles(debounce_cycles)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .sw_i      (sw_i[i]),
      .edge_sel_i(edge_q[i]),
      .stable_o  (stable[i]),
      .hit_o     (hit[i])
    );
  end

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    pend_d = pend_q;
    if (bus.we) begin
      case (bus.addr)
        2'd1:    mask_d = bus.wdata;
        2'd2:    pend_d = pend_q & ~bus.wdata;
        2'd3:    edge_d = bus.wdata;
        default: ;
      endcase
    end
    // new edges OR in after the clear so a colliding set survives
    pend_d = pend_d | hit;
    case (bus.addr)
      2'd0:    rdata_d = stable;
      2'd1:    rdata_d = mask_q;
      2'd2:    rdata_d = pend_q;
      default: rdata_d = edge_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q  <= '0;
      edge_q  <= '1;
      pend_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      irq_q   <= |(pend_q & mask_q);
    end
  end

  assign bus.rdata  = rdata_q;
  assign sw_state_o = stable;
  assign irq_o      = irq_q;
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: directed scenarios plus a random run,
// all compared against a cycle-level behavioural model of the register rules.
module tb_gpio_irq_ctrl;
  localparam int DW = 4;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sw  = '0;
  logic [DW-1:0] sw_state;
  logic          irq;
  int            total = 0;
  int            bad   = 0;

  gpio_irq_ctrl_if #(.data_width(DW)) bus ();

  gpio_irq_ctrl #(.data_width(DW), .debounce_cycles(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_i      (sw),
    .bus       (bus),
    .sw_state_o(sw_state),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted after DB consecutive synchronized
  // samples disagree with the current accepted level.
  logic [DW-1:0] m_d1, m_d2, m_stable, m_mask, m_edge, m_pend, m_rdata;
  logic          m_irq;
  int            m_run [DW];

  task automatic model_edge();
    logic [DW-1:0] synced, set, rd;
    logic          nirq;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_stable = '0; m_mask = '0; m_edge = '1;
      m_pend = '0; m_rdata = '0; m_irq = 1'b0;
      for (int i = 0; i < DW; i++) m_run[i] = 0;
      return;
    end
    set  = '0;
    nirq = |(m_pend & m_mask);
    case (bus.addr)
      2'd0: rd = m_stable;
      2'd1: rd = m_mask;
      2'd2: rd = m_pend;
      default: rd = m_edge;
    endcase
    synced = m_d2; m_d2 = m_d1; m_d1 = sw;
    for (int i = 0; i < DW; i++) begin
      if (synced[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_stable[i] = synced[i];
          m_run[i]    = 0;
          if (synced[i] == m_edge[i]) set[i] = 1'b1;
        end
      end else m_run[i] = 0;
    end
    if (bus.we) begin
      if (bus.addr == 2'd1) m_mask = bus.wdata;
      if (bus.addr == 2'd3) m_edge = bus.wdata;
      if (bus.addr == 2'd2) m_pend = m_pend & ~bus.wdata;
    end
    m_pend  = m_pend | set;
    m_irq   = nirq;
    m_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] a, input logic [DW-1:0] d);
    bus.we = w; bus.addr = a; bus.wdata = d;
  endtask

  task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
    drive(1'b1, a, d); tick(); drive(1'b0, 2'd2, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = '0; drive(1'b0, 2'd3, '0);
    tick(); tick();
    total++;
    if ({sw_state, irq, bus.rdata} !== '0) begin
      bad++; $display("FAIL reset_state got=%h want=0", {sw_state, irq, bus.rdata});
    end
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      total++;
      if (bus.rdata !== 4'hF || irq !== 1'b0 || sw_state !== 4'h0) begin
        bad++; $display("FAIL idle c=%0d rdata=%h irq=%b sw_state=%h want F/0/0", c, bus.rdata, irq, sw_state);
      end
    end
  endtask

  task automatic test_debounce();
    logic [DW-1:0] exp_st;
    logic          exp_pd, exp_irq;
    wr(2'd1, 4'b0001);   // this write edge is edge 0
    sw = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_st  = (k >= 18) ? 4'b0001 : 4'b0000;
      exp_pd  = (k >= 19);
      exp_irq = (k >= 19);
      total++;
      if (sw_state !== exp_st || irq !== exp_irq || bus.rdata !== {3'b000, exp_pd}) begin
        bad++; $display("FAIL debounce k=%0d sw_state=%h irq=%b pend_rd=%h want %h/%b/%h",
                        k, sw_state, irq, bus.rdata, exp_st, exp_irq, {3'b000, exp_pd});
      end
    end
    sw = '0;
    wr(2'd2, 4'hF);
    repeat (22) tick();
    wr(2'd1, 4'h0);
  endtask

  task automatic test_glitch();
    sw[1] = 1'b1;
    repeat (10) tick();
    sw[1] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      total++;
      if (sw_state !== 4'h0 || bus.rdata !== 4'h0 || irq !== 1'b0) begin
        bad++; $display("FAIL glitch c=%0d sw_state=%h pend=%h irq=%b want 0", c, sw_state, bus.rdata, irq);
      end
    end
  endtask

  task automatic test_falling();
    wr(2'd3, 4'b1011);
    sw[2] = 1'b1;
    repeat (24) tick();
    tick();
    total++;
    if (sw_state !== 4'b0100 || bus.rdata !== 4'h0) begin
      bad++; $display("FAIL fall_rise sw_state=%h pend=%h want 4/0", sw_state, bus.rdata);
    end
    sw[2] = 1'b0;
    for (int c = 0; c < 24; c++) begin
      tick();
      total++;
      if ({sw_state, irq, bus.rdata} !== {m_stable, m_irq, m_rdata}) begin
        bad++; $display("FAIL fall_drop c=%0d got=%h want=%h", c, {sw_state, irq, bus.rdata}, {m_stable, m_irq, m_rdata});
      end
    end
    tick();
    total++;
    if (sw_state !== 4'h0 || bus.rdata !== 4'b0100) begin
      bad++; $display("FAIL fall_pend sw_state=%h pend=%h want 0/4", sw_state, bus.rdata);
    end
    wr(2'd2, 4'hF);
    wr(2'd3, 4'hF);
  endtask

  task automatic test_mask_w1c();
    sw = 4'b0101;
    repeat (22) tick();
    sw = 4'b0000;
    repeat (22) tick();
    tick();
    total++;
    if (bus.rdata !== 4'b0101 || irq !== 1'b0) begin
      bad++; $display("FAIL mask_pend pend=%h irq=%b want 5/0", bus.rdata, irq);
    end
    wr(2'd1, 4'b0100);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL mask_edge irq=%b want 0", irq); end
    tick();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL mask_irq irq=%b want 1", irq); end
    wr(2'd2, 4'b0100);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL w1c_edge irq=%b want 1", irq); end
    tick();
    total++;
    if (irq !== 1'b0 || bus.rdata !== 4'b0001) begin
      bad++; $display("FAIL w1c irq=%b pend=%h want 0/1", irq, bus.rdata);
    end
  endtask

  task automatic test_back_to_back();
    sw[3] = 1'b1;   // previous tick is edge 0
    for (int k = 1; k <= 18; k++) begin
      if (k == 18) drive(1'b1, 2'd2, 4'b1000);
      tick();
    end
    drive(1'b0, 2'd2, '0);
    tick();
    total++;
    if (bus.rdata !== 4'b1001) begin
      bad++; $display("FAIL set_wins pend=%h want 9", bus.rdata);
    end
    sw[3] = 1'b0;
    repeat (20) tick();
    wr(2'd2, 4'hF);
  endtask

  task automatic test_reset_mid();
    sw = '0;
    wr(2'd1, 4'hF);
    sw = 4'b0101;
    repeat (22) tick();
    drive(1'b0, 2'd0, '0);
    tick();
    sw = 4'b0100;
    repeat (8) tick();
    total++;
    if (irq !== 1'b1 || sw_state !== 4'b0101) begin
      bad++; $display("FAIL pre_rst irq=%b sw_state=%h want 1/5", irq, sw_state);
    end
    sw = 4'b0001;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    total++;
    if ({sw_state, irq, bus.rdata} !== '0) begin
      bad++; $display("FAIL rst_mid got=%h want=0", {sw_state, irq, bus.rdata});
    end
    rst = 1'b0;
    drive(1'b0, 2'd2, '0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++;
      if ({sw_state, irq, bus.rdata} !== {m_stable, m_irq, m_rdata}) begin
        bad++; $display("FAIL rst_redeb k=%0d got=%h want=%h", k, {sw_state, irq, bus.rdata}, {m_stable, m_irq, m_rdata});
      end
    end
    total++;
    if (sw_state !== 4'b0001 || bus.rdata !== 4'b0001 || irq !== 1'b0) begin
      bad++; $display("FAIL rst_rise sw_state=%h pend=%h irq=%b want 1/1/0", sw_state, bus.rdata, irq);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < DW; i++)
        if ($urandom_range(0, 39) == 0) sw[i] = ~sw[i];
      drive($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), DW'($urandom));
      tick();
      total++;
      if ({sw_state, irq, bus.rdata} !== {m_stable, m_irq, m_rdata}) begin
        bad++; $display("FAIL random c=%0d got=%h want=%h", c, {sw_state, irq, bus.rdata}, {m_stable, m_irq, m_rdata});
      end
    end
  endtask

  initial begin
    drive(1'b0, 2'd0, '0);
    test_reset();
    test_debounce();
    test_glitch();
    test_falling();
    test_mask_w1c();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
